// File: rtl/salaga_uart_pkg.sv
// -----------------------------------------------------------------------------
// salaga_uart_pkg
// Shared definitions for the UART bridge: bus register select values, STATUS
// register bit positions, the TX drain FSM state encoding, and a helper that
// packs the STATUS word.
// -----------------------------------------------------------------------------
package salaga_uart_pkg;

    // Value of ip_data_addr[2] that selects each register
    localparam logic SEL_DATA   = 1'b0;
    localparam logic SEL_STATUS = 1'b1;

    // STATUS register bit positions
    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_RX_OVR      = 3;
    localparam int ST_TX_OVF      = 4;
    localparam int ST_UART_BUSY   = 5;

    // TX drain FSM states
    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_SEND      = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_e;

    function automatic logic [31:0] pack_status(
        input logic tx_full,
        input logic tx_empty,
        input logic rx_nonempty,
        input logic rx_ovr,
        input logic tx_ovf,
        input logic uart_busy
    );
        logic [31:0] s;
        s                 = '0;
        s[ST_TX_FULL]     = tx_full;
        s[ST_TX_EMPTY]    = tx_empty;
        s[ST_RX_NONEMPTY] = rx_nonempty;
        s[ST_RX_OVR]      = rx_ovr;
        s[ST_TX_OVF]      = tx_ovf;
        s[ST_UART_BUSY]   = uart_busy;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through head output.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (clears pointers/count)
//   push         - write push_data this edge (accepted if not full, or if a
//                  pop happens on the same edge)
//   push_data    - data to write
//   pop          - drop the head this edge (ignored when empty)
//   full, empty  - occupancy flags
//   head         - oldest entry, valid whenever empty=0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // At full a simultaneous pop frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_bridge.sv
// -----------------------------------------------------------------------------
// uart_bridge
// Memory-mapped bridge between a processor data bus and a byte UART (buart).
// Register map (selected when ip_data_addr[31]=1, addr[2] picks the register):
//   DATA   (addr[2]=0) write: push byte into TX FIFO; read: pop RX FIFO head
//   STATUS (addr[2]=1) read: {tx_full, tx_empty, rx_nonempty, rx_ovr, tx_ovf,
//                             uart_busy} in bits 0..5; write: clear sticky
//                             rx_ovr (bit3) / tx_ovf (bit4)
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   ip_data_*                  - processor bus (address, write strobe, byte
//                                mask, write data, read strobe)
//   op_data_valid/op_data_to_proc - combinational read response
//   op_uart_wr/op_uart_tx_data - one-cycle transmit strobe and byte to buart
//   op_uart_rd                 - one-cycle receive acknowledge to buart
//   ip_uart_rx_data/ip_uart_valid/ip_uart_busy - buart receive byte/status
// -----------------------------------------------------------------------------
module uart_bridge
    import salaga_uart_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_proc,
    output logic        op_uart_wr,
    output logic [7:0]  op_uart_tx_data,
    output logic        op_uart_rd,
    input  logic [7:0]  ip_uart_rx_data,
    input  logic        ip_uart_busy,
    input  logic        ip_uart_valid
);

    // Bus decode
    logic sel;
    logic is_status;
    logic data_wr;
    logic status_wr;
    logic data_rd;
    logic status_rd;

    assign sel       = ip_data_addr[31];
    assign is_status = (ip_data_addr[2] == SEL_STATUS);
    assign data_wr   = sel & ip_data_wr & ~is_status & ip_data_mask[0];
    assign status_wr = sel & ip_data_wr &  is_status & ip_data_mask[0];
    assign data_rd   = sel & ip_data_rd & ~is_status;
    assign status_rd = sel & ip_data_rd &  is_status;

    // Address/data bits the register map does not decode
    logic unused_bus_bits;
    assign unused_bus_bits = ^{ip_data_addr[30:3], ip_data_addr[1:0],
                               ip_data_mask[3:1], ip_data_from_proc[31:8]};

    // FIFOs
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;
    logic       tx_pop;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] rx_head;
    logic       rx_pop;
    logic       rx_cap;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_wr),
        .push_data (ip_data_from_proc[7:0]),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_cap),
        .push_data (ip_uart_rx_data),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    // RX capture: buart keeps valid high until it sees our acknowledge, so
    // the cycle after a capture is skipped to avoid taking the byte twice.
    logic rx_holdoff;

    assign rx_cap     = ip_uart_valid & ~rx_holdoff & ~reset;
    assign op_uart_rd = rx_cap;
    assign rx_pop     = data_rd & ~rx_empty & ~reset;

    // Sticky error flags and holdoff
    logic rx_ovr;
    logic tx_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_holdoff <= 1'b0;
            rx_ovr     <= 1'b0;
            tx_ovf     <= 1'b0;
        end else begin
            rx_holdoff <= rx_cap;
            // A new error event in the same cycle as a clear wins.
            if (status_wr && ip_data_from_proc[ST_RX_OVR]) rx_ovr <= 1'b0;
            if (rx_cap && rx_full && !rx_pop)              rx_ovr <= 1'b1;
            if (status_wr && ip_data_from_proc[ST_TX_OVF]) tx_ovf <= 1'b0;
            if (data_wr && tx_full && !tx_pop)             tx_ovf <= 1'b1;
        end
    end

    // TX drain FSM
    tx_state_e tx_state;
    tx_state_e tx_state_next;
    logic      tx_send;

    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_send       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !ip_uart_busy) tx_state_next = TX_SEND;
            end
            TX_SEND: begin
                tx_send       = 1'b1;
                tx_state_next = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (ip_uart_busy) tx_state_next = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (!ip_uart_busy) tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign tx_pop          = tx_send;
    assign op_uart_wr      = tx_send & ~reset;
    assign op_uart_tx_data = op_uart_wr ? tx_head : 8'h00;

    // Combinational read response; during reset the state is reported as
    // already cleared so software never sees pre-reset contents.
    logic [31:0] status_word;

    always_comb begin
        if (reset) begin
            status_word = pack_status(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            status_word = pack_status(tx_full, tx_empty, ~rx_empty,
                                      rx_ovr, tx_ovf, ip_uart_busy);
        end
    end

    assign op_data_valid = ip_data_rd & sel;

    always_comb begin
        op_data_to_proc = 32'h0;
        if (status_rd)   op_data_to_proc = status_word;
        else if (rx_pop) op_data_to_proc = {24'h0, rx_head};
    end

endmodule

// File: tb/tb_uart_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_bridge
// Self-checking bench for uart_bridge. Keeps a queue-based model of the TX and
// RX FIFO contents and the sticky flags, derived from the register-map rules,
// and compares bus reads and UART strobes against it.
// -----------------------------------------------------------------------------
module tb_uart_bridge;

    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [31:0] ip_data_addr;
    logic        ip_data_wr;
    logic [3:0]  ip_data_mask;
    logic [31:0] ip_data_from_proc;
    logic        ip_data_rd;
    logic        op_data_valid;
    logic [31:0] op_data_to_proc;
    logic        op_uart_wr;
    logic [7:0]  op_uart_tx_data;
    logic        op_uart_rd;
    logic [7:0]  ip_uart_rx_data;
    logic        ip_uart_busy;
    logic        ip_uart_valid;

    uart_bridge #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .ip_data_addr      (ip_data_addr),
        .ip_data_wr        (ip_data_wr),
        .ip_data_mask      (ip_data_mask),
        .ip_data_from_proc (ip_data_from_proc),
        .ip_data_rd        (ip_data_rd),
        .op_data_valid     (op_data_valid),
        .op_data_to_proc   (op_data_to_proc),
        .op_uart_wr        (op_uart_wr),
        .op_uart_tx_data   (op_uart_tx_data),
        .op_uart_rd        (op_uart_rd),
        .ip_uart_rx_data   (ip_uart_rx_data),
        .ip_uart_busy      (ip_uart_busy),
        .ip_uart_valid     (ip_uart_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic       tx_ovf_m = 1'b0;
    logic       rx_ovr_m = 1'b0;
    int         exp_rd   = 0;

    // Strobe counters sampled mid-cycle
    int wr_pulses = 0;
    int rd_pulses = 0;
    always @(negedge clk) begin
        if (op_uart_wr === 1'b1) wr_pulses <= wr_pulses + 1;
        if (op_uart_rd === 1'b1) rd_pulses <= rd_pulses + 1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish within bound");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] data_addr();
        logic [31:0] a;
        a     = $urandom;
        a[31] = 1'b1;
        a[2]  = 1'b0;
        return a;
    endfunction

    function automatic logic [31:0] status_addr();
        logic [31:0] a;
        a     = $urandom;
        a[31] = 1'b1;
        a[2]  = 1'b1;
        return a;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s    = 32'h0;
        s[0] = (tx_q.size() == TX_DEPTH);
        s[1] = (tx_q.size() == 0);
        s[2] = (rx_q.size() != 0);
        s[3] = rx_ovr_m;
        s[4] = tx_ovf_m;
        s[5] = ip_uart_busy;
        return s;
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        ip_data_addr      = addr;
        ip_data_from_proc = data;
        ip_data_mask      = mask;
        ip_data_wr        = 1'b1;
        if (addr[31] && mask[0]) begin
            if (!addr[2]) begin
                if (tx_q.size() >= TX_DEPTH) tx_ovf_m = 1'b1;
                else                         tx_q.push_back(data[7:0]);
            end else begin
                if (data[3]) rx_ovr_m = 1'b0;
                if (data[4]) tx_ovf_m = 1'b0;
            end
        end
        tick();
        ip_data_wr        = 1'b0;
        ip_data_mask      = 4'h0;
        ip_data_from_proc = 32'h0;
        ip_data_addr      = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata, output logic vld);
        ip_data_addr = addr;
        ip_data_rd   = 1'b1;
        #1;
        rdata = op_data_to_proc;
        vld   = op_data_valid;
        tick();
        ip_data_rd   = 1'b0;
        ip_data_addr = 32'h0;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] exp_s;
        logic [31:0] rd;
        logic        v;
        exp_s = model_status();
        bus_read(status_addr(), rd, v);
        check({tag, "_vld"}, {31'h0, v}, 32'h1);
        check(tag, rd, exp_s);
    endtask

    task automatic check_data_read(input string tag);
        logic [31:0] exp_d;
        logic [31:0] rd;
        logic        v;
        exp_d = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
        bus_read(data_addr(), rd, v);
        check({tag, "_vld"}, {31'h0, v}, 32'h1);
        check(tag, rd, exp_d);
    endtask

    // Waits (bounded) for a transmit strobe, checks its byte, then plays the
    // buart: busy high for busy_cycles once the FSM is waiting for it.
    task automatic wait_tx(input int busy_cycles);
        logic       seen;
        logic [7:0] exp_b;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (op_uart_wr === 1'b1) begin
                seen  = 1'b1;
                exp_b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
                check("tx_byte", {24'h0, op_uart_tx_data}, {24'h0, exp_b});
                tick();
                break;
            end
            check("tx_data_idle", {24'h0, op_uart_tx_data}, 32'h0);
            tick();
        end
        check("tx_strobe_seen", {31'h0, seen}, 32'h1);
        if (busy_cycles > 0) begin
            ip_uart_busy = 1'b1;
            repeat (busy_cycles) tick();
            ip_uart_busy = 1'b0;
        end
    endtask

    task automatic rx_present(input logic [7:0] b, input logic pop_too);
        logic [31:0] exp_d;
        ip_uart_valid   = 1'b1;
        ip_uart_rx_data = b;
        exp_d           = 32'h0;
        if (pop_too) begin
            ip_data_addr = data_addr();
            ip_data_rd   = 1'b1;
            if (rx_q.size() != 0) exp_d = {24'h0, rx_q.pop_front()};
        end
        if (rx_q.size() >= RX_DEPTH) rx_ovr_m = 1'b1;
        else                         rx_q.push_back(b);
        exp_rd++;
        #1;
        check("rx_uart_rd", {31'h0, op_uart_rd}, 32'h1);
        if (pop_too) check("rx_simul_pop", op_data_to_proc, exp_d);
        tick();
        ip_uart_valid = 1'b0;
        ip_data_rd    = 1'b0;
        ip_data_addr  = 32'h0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic        v;
        logic [7:0]  b;
        int          saved;

        reset             = 1'b1;
        ip_data_addr      = 32'h0;
        ip_data_wr        = 1'b0;
        ip_data_mask      = 4'h0;
        ip_data_from_proc = 32'h0;
        ip_data_rd        = 1'b0;
        ip_uart_rx_data   = 8'h0;
        ip_uart_busy      = 1'b0;
        ip_uart_valid     = 1'b0;

        // Reset behaviour
        tick();
        ip_uart_valid = 1'b1;
        #1;
        check("rst_uart_rd", {31'h0, op_uart_rd}, 32'h0);
        check("rst_uart_wr", {31'h0, op_uart_wr}, 32'h0);
        check("rst_tx_data", {24'h0, op_uart_tx_data}, 32'h0);
        bus_read(status_addr(), rd, v);
        check("rst_status_vld", {31'h0, v}, 32'h1);
        check("rst_status", rd, 32'h0000_0002);
        ip_uart_valid = 1'b0;
        tick();
        reset = 1'b0;
        check_status("post_rst_status");

        // Ignored accesses
        bus_write(data_addr(), 32'h0000_00AA, 4'b1110);
        bus_write(32'h0000_0000, 32'h0000_00AB, 4'b1111);
        bus_write(32'h7FFF_FFFC, 32'h0000_0018, 4'b1111);
        ip_data_addr = 32'h0000_0004;
        ip_data_rd   = 1'b1;
        #1;
        check("unsel_rd_vld", {31'h0, op_data_valid}, 32'h0);
        check("unsel_rd_data", op_data_to_proc, 32'h0);
        tick();
        ip_data_rd   = 1'b0;
        ip_data_addr = 32'h0;
        check_status("ignored_wr_status");
        check("no_tx_after_ignored", wr_pulses, 0);

        // Two bytes, each sent once the previous transfer has finished
        bus_write(32'h8000_0000, 32'h0000_0041, 4'h1);
        bus_write(32'h8000_0000, 32'h0000_0042, 4'h1);
        wait_tx(3);
        check("tx_pulses_1", wr_pulses, 1);
        wait_tx(3);
        check("tx_pulses_2", wr_pulses, 2);
        repeat (3) tick();
        check_status("tx_drained_status");

        // Overflow with buart stuck busy
        ip_uart_busy = 1'b1;
        for (int i = 0; i < 9; i++) bus_write(data_addr(), $urandom, 4'h1);
        check_status("tx_full_ovf_status");
        bus_write(status_addr(), 32'h0000_0010, 4'b1110);
        check_status("tx_ovf_masked_clr");
        bus_write(status_addr(), 32'h0000_0010, 4'h1);
        check_status("tx_ovf_cleared");
        check("tx_none_while_busy", wr_pulses, 2);
        ip_uart_busy = 1'b0;
        for (int i = 0; i < TX_DEPTH; i++) wait_tx(2);
        repeat (3) tick();
        check("tx_pulses_10", wr_pulses, 10);
        check_status("tx_drain8_status");

        // Single RX byte
        rx_present(8'h5A, 1'b0);
        check_status("rx_one_status");
        check_data_read("rx_read_5a");
        check_data_read("rx_read_empty");

        // Holdoff: valid held for three cycles captures twice
        b = 8'($urandom);
        ip_uart_valid   = 1'b1;
        ip_uart_rx_data = b;
        #1;
        check("holdoff_rd0", {31'h0, op_uart_rd}, 32'h1);
        tick();
        check("holdoff_rd1", {31'h0, op_uart_rd}, 32'h0);
        tick();
        check("holdoff_rd2", {31'h0, op_uart_rd}, 32'h1);
        tick();
        ip_uart_valid = 1'b0;
        rx_q.push_back(b);
        rx_q.push_back(b);
        exp_rd += 2;
        tick();
        // Unselected read must not pop
        ip_data_addr = 32'h0000_0000;
        ip_data_rd   = 1'b1;
        tick();
        ip_data_rd   = 1'b0;
        check_data_read("holdoff_read_a");
        check_data_read("holdoff_read_b");

        // RX fill, overrun, and push+pop at full
        for (int i = 0; i < RX_DEPTH; i++) rx_present(8'($urandom), 1'b0);
        check_status("rx_full_status");
        rx_present(8'($urandom), 1'b0);
        check_status("rx_ovr_status");
        bus_write(status_addr(), 32'h0000_0018, 4'b1110);
        check_status("rx_ovr_masked_clr");
        bus_write(status_addr(), 32'h0000_0008, 4'h1);
        check_status("rx_ovr_cleared");
        rx_present(8'($urandom), 1'b1);
        check_status("rx_simul_status");
        for (int i = 0; i < RX_DEPTH; i++) check_data_read("rx_drain");
        check_data_read("rx_drain_empty");
        check_status("rx_empty_status");
        check("rx_ack_count", rd_pulses, exp_rd);

        // Reset while the FSM waits for busy with 3 bytes queued
        bus_write(data_addr(), $urandom, 4'h1);
        wait_tx(0);
        for (int i = 0; i < 3; i++) bus_write(data_addr(), $urandom, 4'h1);
        check_status("pre_rst_status");
        saved = wr_pulses;
        reset = 1'b1;
        bus_read(status_addr(), rd, v);
        check("mid_rst_status", rd, 32'h0000_0002);
        check("mid_rst_uart_wr", {31'h0, op_uart_wr}, 32'h0);
        tick();
        reset = 1'b0;
        tx_q.delete();
        check_status("after_rst_status");
        for (int i = 0; i < 10; i++) begin
            check("after_rst_no_wr", {31'h0, op_uart_wr}, 32'h0);
            tick();
        end
        check("after_rst_pulses", wr_pulses, saved);
        bus_write(data_addr(), $urandom, 4'h1);
        wait_tx(2);
        repeat (3) tick();
        check("refill_pulses", wr_pulses, saved + 1);
        check_status("final_status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
